// File: rtl/fsram_pingpong_ctrl.sv
// Ping-pong scheduler for the FSRAM1/FSRAM2 bank pair: loader fills one bank while compute drains the other.
// Latency: bank CEN/WEN/A are combinational on the accepted cycle; rd_valid/rd_sel/rd_last follow one cycle later.
// Backpressure: wr_ready drops while the target bank is full; reads wait on rd_ready and a full bank.
// Optional macro FSRAM_PP_STALL_CNT_EN adds saturating write/read stall counters.
module fsram_pingpong_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int SRAM_NUM = 8,
    parameter int TILE_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   frame_len,
    input  logic [TILE_W-1:0]   num_tiles,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic                rd_ready,
    output logic                rd_valid,
    output logic                rd_sel,
    output logic                rd_last,
    output logic                busy,
    output logic                done,
    output logic                CEN_1,
    output logic [SRAM_NUM-1:0] WEN_1,
    output logic [ADDR_W-1:0]   A_1,
    output logic                CEN_2,
    output logic [SRAM_NUM-1:0] WEN_2,
    output logic [ADDR_W-1:0]   A_2
`ifdef FSRAM_PP_STALL_CNT_EN
    ,
    output logic [15:0]         wr_stall_cnt,
    output logic [15:0]         rd_stall_cnt
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   len_m1_q, len_m1_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [TILE_W-1:0]   wr_left_q, wr_left_d;
    logic [TILE_W-1:0]   rd_left_q, rd_left_d;
    logic [1:0]          full_q, full_d;
    logic                wb_q, wb_d;
    logic                rb_q, rb_d;
    logic                wr_ready_q, wr_ready_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_sel_q, rd_sel_d;
    logic                rd_last_q, rd_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   a1_q, a2_q;

    logic                start_acc;
    logic                wr_fire, rd_issue, wr_end, rd_end;
    logic                wr_b0, wr_b1, rd_b0, rd_b1;

    // Event decode: accepted start, write/read fire and end-of-tile
    always_comb begin
        start_acc = (state_q == ST_IDLE) && start && (frame_len != '0) && (num_tiles != '0);
        wr_fire   = wr_valid && wr_ready_q;
        rd_issue  = (state_q == ST_RUN) && rd_ready && full_q[rb_q];
        wr_end    = wr_fire && (wr_cnt_q == len_m1_q);
        rd_end    = rd_issue && (rd_cnt_q == len_m1_q);
        wr_b0     = wr_fire && !wb_q;
        wr_b1     = wr_fire && wb_q;
        rd_b0     = rd_issue && !rb_q;
        rd_b1     = rd_issue && rb_q;
    end

    // Next-state: FSM, counters and bank full flags; registered outputs derive from next state
    always_comb begin
        state_d   = state_q;
        len_m1_d  = len_m1_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_left_d = wr_left_q;
        rd_left_d = rd_left_q;
        full_d    = full_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d   = ST_RUN;
                    len_m1_d  = frame_len - 1'b1;
                    wr_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    wr_left_d = num_tiles;
                    rd_left_d = num_tiles;
                    full_d    = 2'b00;
                    wb_d      = 1'b0;
                    rb_d      = 1'b0;
                end
            end
            ST_RUN: begin
                // write and read always target different banks, so both flag updates can apply together
                if (wr_fire) begin
                    if (wr_end) begin
                        wr_cnt_d     = '0;
                        full_d[wb_q] = 1'b1;
                        wb_d         = ~wb_q;
                        wr_left_d    = wr_left_q - 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
                if (rd_issue) begin
                    if (rd_end) begin
                        rd_cnt_d     = '0;
                        full_d[rb_q] = 1'b0;
                        rb_d         = ~rb_q;
                        rd_left_d    = rd_left_q - 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
                if (rd_left_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // wr_ready looks at post-update flags so a just-filled bank is never written again
        wr_ready_d = (state_d == ST_RUN) && !full_d[wb_d] && (wr_left_d != '0);
        rd_valid_d = rd_issue;
        rd_sel_d   = rd_issue ? rb_q : rd_sel_q;
        rd_last_d  = rd_end;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    // Bank drive: the active side owns the bank; an idle bank is deselected and holds its address
    always_comb begin
        CEN_1 = !(wr_b0 || rd_b0);
        CEN_2 = !(wr_b1 || rd_b1);
        WEN_1 = wr_b0 ? {SRAM_NUM{1'b0}} : {SRAM_NUM{1'b1}};
        WEN_2 = wr_b1 ? {SRAM_NUM{1'b0}} : {SRAM_NUM{1'b1}};
        A_1   = wr_b0 ? wr_cnt_q : (rd_b0 ? rd_cnt_q : a1_q);
        A_2   = wr_b1 ? wr_cnt_q : (rd_b1 ? rd_cnt_q : a2_q);
    end

    // State register with async reset; a reset mid-job simply abandons it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_m1_q   <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wr_left_q  <= '0;
            rd_left_q  <= '0;
            full_q     <= 2'b00;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            a1_q       <= '0;
            a2_q       <= '0;
        end else begin
            state_q    <= state_d;
            len_m1_q   <= len_m1_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_left_q  <= wr_left_d;
            rd_left_q  <= rd_left_d;
            full_q     <= full_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_sel_q   <= rd_sel_d;
            rd_last_q  <= rd_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            a1_q       <= A_1;
            a2_q       <= A_2;
        end
    end

    assign wr_ready = wr_ready_q;
    assign rd_valid = rd_valid_q;
    assign rd_sel   = rd_sel_q;
    assign rd_last  = rd_last_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef FSRAM_PP_STALL_CNT_EN
    logic [15:0] wr_stall_q, rd_stall_q;
    logic        wr_stall_ev, rd_stall_ev;

    always_comb begin
        wr_stall_ev = (state_q == ST_RUN) && wr_valid && !wr_ready_q && (wr_left_q != '0);
        rd_stall_ev = (state_q == ST_RUN) && rd_ready && !full_q[rb_q] && (rd_left_q != '0);
    end

    // Saturating stall counters, cleared by reset or a newly accepted job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_stall_q <= '0;
            rd_stall_q <= '0;
        end else if (start_acc) begin
            wr_stall_q <= '0;
            rd_stall_q <= '0;
        end else begin
            if (wr_stall_ev && (wr_stall_q != 16'hFFFF)) wr_stall_q <= wr_stall_q + 16'd1;
            if (rd_stall_ev && (rd_stall_q != 16'hFFFF)) rd_stall_q <= rd_stall_q + 16'd1;
        end
    end

    assign wr_stall_cnt = wr_stall_q;
    assign rd_stall_cnt = rd_stall_q;
`endif

endmodule

// File: tb/tb_fsram_pingpong_ctrl.sv
// Directed bench for fsram_pingpong_ctrl: reset, single tile, multi-tile overlap, reader stall, ignored starts.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fsram_pingpong_ctrl;

    logic        clk, rst, start, wr_valid, rd_ready;
    logic [11:0] frame_len;
    logic [7:0]  num_tiles;
    logic        wr_ready, rd_valid, rd_sel, rd_last, busy, done;
    logic        CEN_1, CEN_2;
    logic [7:0]  WEN_1, WEN_2;
    logic [11:0] A_1, A_2;
`ifdef FSRAM_PP_STALL_CNT_EN
    logic [15:0] wr_stall_cnt, rd_stall_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    fsram_pingpong_ctrl #(.ADDR_W(12), .SRAM_NUM(8), .TILE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .num_tiles(num_tiles),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_sel(rd_sel), .rd_last(rd_last), .busy(busy), .done(done),
        .CEN_1(CEN_1), .WEN_1(WEN_1), .A_1(A_1), .CEN_2(CEN_2), .WEN_2(WEN_2), .A_2(A_2)
`ifdef FSRAM_PP_STALL_CNT_EN
        , .wr_stall_cnt(wr_stall_cnt), .rd_stall_cnt(rd_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrd, ovl, nwr, done_at;
        rst = 1'b1; start = 1'b0; frame_len = '0; num_tiles = '0; wr_valid = 1'b0; rd_ready = 1'b0;

        // ---- reset values ----
        @(negedge clk); #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_sel",   32'(rd_sel),   32'd0);
        chk("rst_rd_last",  32'(rd_last),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_cen1",     32'(CEN_1),    32'd1);
        chk("rst_cen2",     32'(CEN_2),    32'd1);
        chk("rst_wen1",     32'(WEN_1),    32'hFF);
        chk("rst_wen2",     32'(WEN_2),    32'hFF);
        chk("rst_a1",       32'(A_1),      32'd0);
        chk("rst_a2",       32'(A_2),      32'd0);
        @(negedge clk); rst = 1'b0;

        // ---- test 1: reset after 5 writes ----
        start = 1'b1; frame_len = 12'd8; num_tiles = 8'd2; wr_valid = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("t1_a1_word5", 32'(A_1),   32'd5);
        chk("t1_cen1_wr",  32'(CEN_1), 32'd0);
        rst = 1'b1; #1;
        chk("t1_async_cen1",     32'(CEN_1),    32'd1);
        chk("t1_async_a1",       32'(A_1),      32'd0);
        chk("t1_async_wr_ready", 32'(wr_ready), 32'd0);
        chk("t1_async_busy",     32'(busy),     32'd0);
        @(negedge clk); #1;
        chk("t1_rst_done",  32'(done),  32'd0);
        chk("t1_rst_wen1",  32'(WEN_1), 32'hFF);
        rst = 1'b0; wr_valid = 1'b0;

        // ---- test 5a: start with frame_len=0 ignored ----
        @(negedge clk);
        start = 1'b1; frame_len = 12'd0; num_tiles = 8'd3;
        @(negedge clk); start = 1'b0; #1;
        chk("t5_len0_busy",     32'(busy),     32'd0);
        chk("t5_len0_wr_ready", 32'(wr_ready), 32'd0);

        // ---- test 5b: start during RUN ignored (len 2, 1 tile kept) ----
        @(negedge clk);
        start = 1'b1; frame_len = 12'd2; num_tiles = 8'd1;
        @(negedge clk); start = 1'b1; frame_len = 12'd7; num_tiles = 8'd9;
        @(negedge clk); start = 1'b0; #1;
        chk("t5_run_busy",     32'(busy),     32'd1);
        chk("t5_run_wr_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1; #1;
        chk("t5_w0_a1", 32'(A_1), 32'd0);
        @(negedge clk); #1;
        chk("t5_w1_a1", 32'(A_1), 32'd1);
        @(negedge clk); #1;
        chk("t5_len_kept_wr_ready", 32'(wr_ready), 32'd0);
        chk("t5_busy_kept",         32'(busy),     32'd1);
        wr_valid = 1'b0; rd_ready = 1'b1; #1;
        chk("t5_r0_cen1", 32'(CEN_1), 32'd0);
        chk("t5_r0_wen1", 32'(WEN_1), 32'hFF);
        chk("t5_r0_a1",   32'(A_1),   32'd0);
        @(negedge clk); #1;
        chk("t5_r1_a1",    32'(A_1),      32'd1);
        chk("t5_r1_valid", 32'(rd_valid), 32'd1);
        @(negedge clk); #1;
        chk("t5_done",    32'(done),    32'd1);
        chk("t5_rd_last", 32'(rd_last), 32'd1);
        rd_ready = 1'b0;
        @(negedge clk); #1;
        chk("t5_idle_busy", 32'(busy), 32'd0);

        // ---- test 2: frame_len=4, one tile ----
        @(negedge clk);
        start = 1'b1; frame_len = 12'd4; num_tiles = 8'd1; wr_valid = 1'b1; rd_ready = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_wr_cen1", 32'(CEN_1), 32'd0);
            chk("t2_wr_wen1", 32'(WEN_1), 32'h00);
            chk("t2_wr_a1",   32'(A_1),   32'(i));
            chk("t2_wr_cen2", 32'(CEN_2), 32'd1);
            @(negedge clk); #1;
        end
        chk("t2_wr_ready_off", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_rd_cen1",  32'(CEN_1),    32'd0);
            chk("t2_rd_wen1",  32'(WEN_1),    32'hFF);
            chk("t2_rd_a1",    32'(A_1),      32'(i));
            chk("t2_rd_valid", 32'(rd_valid), 32'(i != 0));
            chk("t2_rd_last",  32'(rd_last),  32'd0);
            chk("t2_rd_done",  32'(done),     32'd0);
            @(negedge clk); #1;
        end
        chk("t2_last_valid", 32'(rd_valid), 32'd1);
        chk("t2_last_last",  32'(rd_last),  32'd1);
        chk("t2_last_sel",   32'(rd_sel),   32'd0);
        chk("t2_done",       32'(done),     32'd1);
        chk("t2_busy_done",  32'(busy),     32'd1);
        chk("t2_cen1_idle",  32'(CEN_1),    32'd1);
        chk("t2_a1_hold",    32'(A_1),      32'd3);
        @(negedge clk); #1;
        chk("t2_done_pulse", 32'(done),     32'd0);
        chk("t2_busy_off",   32'(busy),     32'd0);
        chk("t2_valid_off",  32'(rd_valid), 32'd0);

        // ---- test 3: frame_len=3, 4 tiles, both sides always ready ----
        @(negedge clk);
        start = 1'b1; frame_len = 12'd3; num_tiles = 8'd4; wr_valid = 1'b1; rd_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        nrd = 0; ovl = 0; done_at = -1;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            #1;
            if (rd_valid) nrd++;
            if (!CEN_1 && !CEN_2) ovl++;
            if (done) done_at = c;
            if (c == 4) begin
                chk("t3_c4_a1",   32'(A_1),    32'd1);
                chk("t3_c4_a2",   32'(A_2),    32'd1);
                chk("t3_c4_wen2", 32'(WEN_2),  32'h00);
                chk("t3_c4_wen1", 32'(WEN_1),  32'hFF);
                chk("t3_c4_sel",  32'(rd_sel), 32'd0);
            end
            if (c == 7) chk("t3_c7_sel", 32'(rd_sel), 32'd1);
            if (c == 15) chk("t3_c15_sel", 32'(rd_sel), 32'd1);
            @(negedge clk);
        end
        chk("t3_done_cycle", 32'(done_at), 32'd15);
        chk("t3_reads",      32'(nrd),     32'd12);
        chk("t3_overlap",    32'(ovl),     32'd9);
`ifdef FSRAM_PP_STALL_CNT_EN
        chk("t3_rd_stall", 32'(rd_stall_cnt), 32'd3);
        chk("t3_wr_stall", 32'(wr_stall_cnt), 32'd0);
`endif

        // ---- test 4: frame_len=2, 3 tiles, reader held off 20 cycles ----
        start = 1'b1; frame_len = 12'd2; num_tiles = 8'd3; wr_valid = 1'b1; rd_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        nwr = 0; done_at = -1;
        for (int c = 0; c < 60 && done_at < 0; c++) begin
            rd_ready = (c >= 20);
            #1;
            if (wr_valid && wr_ready) nwr++;
            if (done) done_at = c;
            if (c == 3) chk("t4_c3_wr_ready", 32'(wr_ready), 32'd1);
            if (c == 4) chk("t4_c4_wr_ready", 32'(wr_ready), 32'd0);
            if (c == 20) begin
                chk("t4_c20_wr_ready", 32'(wr_ready), 32'd0);
                chk("t4_c20_rd_a1",    32'(A_1),      32'd0);
                chk("t4_c20_rd_wen1",  32'(WEN_1),    32'hFF);
`ifdef FSRAM_PP_STALL_CNT_EN
                chk("t4_wr_stall", 32'(wr_stall_cnt), 32'd16);
`endif
            end
            if (c == 21) chk("t4_c21_wr_ready", 32'(wr_ready), 32'd0);
            if (c == 22) begin
                chk("t4_c22_wr_ready", 32'(wr_ready), 32'd1);
                chk("t4_c22_cen1",     32'(CEN_1),    32'd0);
                chk("t4_c22_wen1",     32'(WEN_1),    32'h00);
                chk("t4_c22_cen2",     32'(CEN_2),    32'd0);
                chk("t4_c22_a2",       32'(A_2),      32'd0);
            end
            @(negedge clk);
        end
        chk("t4_done_cycle", 32'(done_at), 32'd26);
        chk("t4_writes",     32'(nwr),     32'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
